// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush/halt controller for a five-stage core
// Arbitrates data-memory waits, redirects, load-use hazards and fetch misses into register enables.
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_op_in,
    input  logic        dmem_done,
    input  logic        imem_done,
    input  logic        ld_ex,
    input  logic [2:0]  ld_dst,
    input  logic [2:0]  id_rs,
    input  logic [2:0]  id_rt,
    input  logic        id_rs_use,
    input  logic        id_rt_use,
    input  logic        redirect,
    input  logic        dump_mem,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        dmem_req,
    output logic        halted,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DWAIT = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_halted;
    logic [15:0] r_stall_cnt;
    logic        w_advance;
    logic        w_load_use;

    assign w_load_use = ld_ex & ((id_rs_use & (id_rs == ld_dst)) |
                                 (id_rt_use & (id_rt == ld_dst)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_RUN;
            r_halted    <= 1'b0;
            r_stall_cnt <= 16'd0;
        end else begin
            r_state  <= w_next;
            r_halted <= (w_next == S_HALT);
            // Halt parks pc_en low forever; those cycles are not stalls.
            if (!pc_en && (r_state != S_HALT) && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        dmem_req   = 1'b0;
        w_advance  = 1'b0;
        w_next     = r_state;

        if (!rst) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            w_next     = S_RUN;
        end else begin
            case (r_state)
                S_RUN: begin
                    dmem_req = mem_op_in;
                    if (mem_op_in && !dmem_done)
                        w_next = S_DWAIT;
                    else
                        w_advance = 1'b1;
                end
                S_DWAIT: begin
                    dmem_req = 1'b1;
                    if (dmem_done)
                        w_advance = 1'b1;
                end
                S_HALT: begin
                    w_next = S_HALT;
                end
                default: begin
                    w_next = S_RUN;
                end
            endcase
        end

        // Pipeline moves this cycle: apply redirect > load-use > fetch-miss.
        if (w_advance) begin
            w_next   = dump_mem ? S_HALT : S_RUN;
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (redirect) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (w_load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end else if (!imem_done) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
            end
        end
    end

    assign halted    = r_halted;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-low (asserted when 0, sampled on rising clk).
REQ-003 SHALL have port mem_op_in, input, 1 bit: EX/MEM register holds a load or store (mem_to_reg_out | mem_write_out).
REQ-004 SHALL have port dmem_done, input, 1 bit: data memory completes the current access this cycle.
REQ-005 SHALL have port imem_done, input, 1 bit: instruction memory returns a valid word this cycle.
REQ-006 SHALL have port ld_ex, input, 1 bit: ID/EX holds a load.
REQ-007 SHALL have port ld_dst, input, 3 bits: destination register of the load in ID/EX.
REQ-008 SHALL have ports id_rs and id_rt, input, 3 bits each: source registers of the instruction in ID.
REQ-009 SHALL have ports id_rs_use and id_rt_use, input, 1 bit each: ID instruction reads rs / rt.
REQ-010 SHALL have port redirect, input, 1 bit: taken branch or jr resolved in EX.
REQ-011 SHALL have port dump_mem, input, 1 bit: halt/dump instruction in MEM.
REQ-012 SHALL have ports pc_en, ifid_en, idex_en, exmem_en, memwb_en, output, 1 bit each: pipeline register enables.
REQ-013 SHALL have ports ifid_flush and idex_flush, output, 1 bit each: load a bubble into that register on this edge.
REQ-014 SHALL have port dmem_req, output, 1 bit: hold data-memory request active.
REQ-015 SHALL have port halted, output, 1 bit: processor halted.
REQ-016 SHALL have port stall_cnt, output, 16 bits: count of stalled cycles.

Function
REQ-017 SHALL implement states RUN, DWAIT, HALT.
REQ-018 Condition priority SHALL be: reset > data-memory stall > redirect > load-use hazard > fetch miss.
REQ-019 RUN, mem_op_in=1 and dmem_done=0: all five enables 0, flushes 0, dmem_req=1; next state DWAIT.
REQ-020 RUN, mem_op_in=1 and dmem_done=1: no stall (zero added latency), dmem_req=1, remaining rules apply.
REQ-021 DWAIT: all enables 0, flushes 0, dmem_req=1 until dmem_done=1; on that cycle all enables 1, remaining rules apply, next state RUN (or HALT per REQ-025).
REQ-022 redirect=1 (no memory stall): all enables 1, ifid_flush=1, idex_flush=1; load-use and fetch-miss ignored that cycle.
REQ-023 Load-use hazard = ld_ex & ((id_rs_use & id_rs==ld_dst) | (id_rt_use & id_rt==ld_dst)): pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1; exactly one bubble per hazard.
REQ-024 Fetch miss (imem_done=0, none above): pc_en=0, ifid_flush=1, other enables 1.
REQ-025 dump_mem=1 on a cycle the pipeline advances (RUN without new stall, or DWAIT with dmem_done=1): next state HALT.
REQ-026 HALT: all enables 0, flushes 0, dmem_req=0, halted=1; exits only on reset; all inputs ignored.
REQ-027 Otherwise (RUN, no condition): all enables 1, flushes 0, dmem_req=mem_op_in, halted=0.
REQ-028 stall_cnt SHALL increment by 1 each cycle pc_en=0 while state is not HALT and rst=1, saturating at 0xFFFF (no wrap).
REQ-029 Outputs other than stall_cnt and halted SHALL be combinational from state and inputs; state, halted and stall_cnt registered.

Reset
REQ-030 While rst=0: state←RUN, stall_cnt←0, halted←0; all enables 0, ifid_flush=idex_flush=1, dmem_req=0.
REQ-031 Reset asserted in DWAIT or HALT SHALL abandon the access/halt; first cycle after release is RUN.

Verification
REQ-032 Load, mem_op_in=1, dmem_done low 3 cycles then 1 -> all enables 0 for 3 cycles, dmem_req=1 for 4 cycles, enables 1 on 4th, stall_cnt=3.
REQ-033 ld_ex=1, ld_dst=3, id_rt=3, id_rt_use=1 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; stall_cnt +1; next cycle all enables 1.
REQ-034 redirect=1 with load-use hazard and imem_done=0 same cycle -> pc_en=1, ifid_flush=idex_flush=1, stall_cnt unchanged.
REQ-035 dump_mem=1 in RUN -> halted=1 next cycle, all enables 0 held 10 cycles regardless of inputs; rst=0 -> RUN, halted=0.
REQ-036 Force 65 540 fetch-miss cycles -> stall_cnt stops at 0xFFFF; rst=0 in DWAIT -> dmem_req=0, stall_cnt=0 next cycle.
